// File: rtl/pulse_scheduler.sv
// Quantum pulse scheduler: FIFO of quantum instructions, each issued after its [31:16] delay.
// Optional issue/drop statistics ports are enabled by defining PULSE_SCHED_STATS_EN.
module pulse_scheduler #(
  parameter int unsigned DEPTH          = 16,
  parameter logic [6:0]  OPCODE_QUANTUM = 7'h5B
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pulse_inst_in,
  input  logic                     pulse_inst_in_valid,
  output logic [31:0]              pulse_out_inst,
  output logic                     pulse_out_valid,
  input  logic                     pulse_out_ready,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
`ifdef PULSE_SCHED_STATS_EN
  output logic [31:0]              issued_count,
  output logic [15:0]              dropped_count,
`endif
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StIssue} state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     hold_q;
  logic [15:0]     delay_q;
  logic            overflow_q;
  logic [31:0]     head;
  logic            is_quantum, push, drop, pop, handshake;

  assign head       = mem_q[rd_ptr_q];
  assign is_quantum = pulse_inst_in_valid && (pulse_inst_in[6:0] == OPCODE_QUANTUM);
  assign fifo_full  = (count_q == CntW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  // Full is judged on registered occupancy, so a same-cycle pop never rescues a push.
  assign push       = is_quantum && !fifo_full;
  assign drop       = is_quantum && fifo_full;
  assign pop        = (state_q == StIdle) && !fifo_empty;
  assign handshake  = (state_q == StIssue) && pulse_out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pulse_inst_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      delay_q <= '0;
    end else if (pop) begin
      hold_q  <= head;
      delay_q <= head[31:16];
    end else if (state_q == StWait) begin
      delay_q <= delay_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = (head[31:16] == 16'd0) ? StIssue : StWait;
      // WAIT is only entered with a nonzero delay, so the count always passes through 1.
      StWait:  if (delay_q == 16'd1) state_d = StIssue;
      StIssue: if (pulse_out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pulse_out_valid = (state_q == StIssue);
    pulse_out_inst  = pulse_out_valid ? hold_q : '0;
  end

`ifdef PULSE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_count  <= '0;
      dropped_count <= '0;
    end else begin
      if (handshake) issued_count <= issued_count + 32'd1;
      if (drop && (dropped_count != 16'hFFFF)) dropped_count <= dropped_count + 16'd1;
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule
